sprite_anim_ctrl: RTL and testbench
===================================

SPRITE_ANIM_CTRL -- requirements
Module: sprite_anim_ctrl

Interface
REQ-001 SHALL have parameter INIT_X, default 10'd100: posx value after reset.
REQ-002 SHALL have parameter POS_MIN, default 10'd0: lowest legal posx.
REQ-003 SHALL have parameter POS_MAX, default 10'd490: highest legal posx (640 - 150 sprite width).
REQ-004 SHALL have parameter FWD_STEP, default 10'd2: pixels per frame in FORWARD.
REQ-005 SHALL have parameter BWD_STEP, default 10'd1: pixels per frame in BACKWARD.
REQ-006 SHALL have parameters START_FRAMES / END_FRAMES / PULL_FRAMES, defaults 5 / 3 / 4: frames spent in each attack phase; each SHALL be >= 1.
REQ-007 SHALL use the ports below; there is one clock; rst is synchronous and active-high.
- clk  input  1  system/pixel clock
- rst  input  1  synchronous active-high reset
- frame_tick  input  1  one-clk pulse per video frame
- btn_fwd  input  1  forward request, level
- btn_bwd  input  1  backward request, level
- btn_attack  input  1  attack request, level
- currentstate  output  4  sprite selector: 0 IDLE, 1 FORWARD, 2 BACKWARD, 3 ATK_START, 4 ATK_END, 5 ATK_PULL
- posx  output  10  player X position fed to the sprite renderer
- hitbox_active  output  1  high exactly while currentstate==ATK_END
- attack_busy  output  1  high while currentstate is 3, 4 or 5

Function
REQ-008 All state, counter and posx updates SHALL occur only on a clk edge with frame_tick=1; with frame_tick=0 every register SHALL hold.
REQ-009 Buttons SHALL be sampled only on frame_tick edges; outputs SHALL reflect the new state one clk after that edge.
REQ-010 From IDLE, FORWARD or BACKWARD, decision priority on each tick: attack trigger -> ATK_START; else btn_fwd XOR btn_bwd -> FORWARD or BACKWARD; else IDLE. Both directions pressed SHALL yield IDLE.
REQ-011 Attack trigger SHALL require btn_attack=1 and the arm flag set. The arm flag SHALL be set at any tick where btn_attack=0 and cleared when an attack starts; a held button SHALL NOT retrigger.
REQ-012 Attack phases SHALL be non-interruptible: ATK_START lasts START_FRAMES ticks, then ATK_END for END_FRAMES ticks, then ATK_PULL for PULL_FRAMES ticks, then normal decision per REQ-010 on the next tick.
REQ-013 The phase frame counter SHALL load 0 on phase entry, increment per tick, and advance phase when count == N-1.
REQ-014 In FORWARD each tick, posx SHALL become min(posx + FWD_STEP, POS_MAX); arithmetic SHALL be 11-bit so no wrap occurs.
REQ-015 In BACKWARD each tick, posx SHALL become POS_MIN if posx < POS_MIN + BWD_STEP, else posx - BWD_STEP.
REQ-016 posx SHALL NOT change in IDLE or any attack phase.
REQ-017 Movement SHALL apply on the tick that enters FORWARD/BACKWARD (state and posx update on the same edge).
REQ-018 Encodings 6-15 SHALL be unreachable; if ever present, the next tick SHALL return to IDLE.

Reset
REQ-019 With rst=1 at a clk edge, regardless of frame_tick: currentstate=0, posx=INIT_X, counter=0, arm flag=1, hitbox_active=0, attack_busy=0.
REQ-020 rst asserted mid-attack SHALL abort the attack immediately; rst SHALL take priority over frame_tick.

Structure
REQ-021 State encodings 0-5 and the 640-pixel screen-width constant SHALL live in shared package sprite_state_pkg, also used by the sprite ROM selector.
REQ-022 The phase counter SHALL be a sub-module anim_phase_timer (load, tick enable, terminal-count output); the FSM and position logic stay in sprite_anim_ctrl.
REQ-023 hitbox_active and attack_busy SHALL be decoded from the registered state, with no extra latency.

Verification
REQ-024 Reset then 10 ticks with btn_fwd=1 -> currentstate=1 from the first tick, posx=120.
REQ-025 posx=489, btn_fwd held 3 ticks -> posx=490 and then holds at 490; btn_bwd from posx=0 -> posx stays 0.
REQ-026 btn_attack=1 held 20 ticks from IDLE -> states 3 (5 ticks), 4 (3 ticks, hitbox_active=1), 5 (4 ticks), then 0; no second attack until btn_attack=0 at some tick.
REQ-027 btn_fwd=1 and btn_bwd=1 together -> currentstate=0, posx unchanged; btn_fwd with btn_attack on the same tick -> 3.
REQ-028 rst pulsed during ATK_END -> next clk currentstate=0, posx=100, hitbox_active=0.
REQ-029 Buttons toggled between ticks with frame_tick=0 -> no output change until the next tick.

Source files
------------

// File: rtl/sprite_state_pkg.sv
// sprite_state_pkg
// Shared definitions for the sprite animation controller and the sprite ROM
// selector: the sprite/state encodings presented on currentstate, the screen
// width, and the width of the attack-phase frame counter.
package sprite_state_pkg;

  // Visible screen width in pixels. The rightmost legal sprite X is this value
  // minus the sprite width.
  localparam int SCREEN_W = 640;

  // Phase counter width. Each attack phase may last up to 2**CNT_W frames.
  localparam int CNT_W = 8;

  // Sprite selector / controller state. Codes 6-15 are never produced.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FORWARD   = 4'd1,
    ST_BACKWARD  = 4'd2,
    ST_ATK_START = 4'd3,
    ST_ATK_END   = 4'd4,
    ST_ATK_PULL  = 4'd5
  } state_e;

  // True for the three attack phases.
  function automatic logic is_attack(input logic [3:0] s);
    return (s == ST_ATK_START) || (s == ST_ATK_END) || (s == ST_ATK_PULL);
  endfunction

endpackage

// File: rtl/anim_phase_timer.sv
// anim_phase_timer
// Frame counter for one attack phase. It restarts at 0 when load is high,
// advances by one on each enabled tick, and flags the terminal count when
// the count equals last_cnt (phase length minus one).
// Ports:
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   load      - restart the count at 0; takes priority over tick_en
//   tick_en   - advance the count by one
//   last_cnt  - terminal value for the current phase
//   tc        - high while count == last_cnt
module anim_phase_timer
  import sprite_state_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             tick_en,
  input  logic [CNT_W-1:0] last_cnt,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (tick_en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == last_cnt);

endmodule

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl
// Player sprite controller: picks the sprite state (idle, walk forward, walk
// backward, three-phase attack) and moves the player X position once per
// video frame. Everything advances only on clocks where frame_tick is high.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   frame_tick      - one-clock pulse per video frame
//   btn_fwd/bwd     - movement requests (levels)
//   btn_attack      - attack request (level; must be released to re-arm)
//   currentstate    - sprite selector code (see sprite_state_pkg)
//   posx            - player X position
//   hitbox_active   - high while in ATK_END
//   attack_busy     - high while in any attack phase
module sprite_anim_ctrl
  import sprite_state_pkg::*;
#(
  parameter logic [9:0] INIT_X       = 10'd100,
  parameter logic [9:0] POS_MIN      = 10'd0,
  parameter logic [9:0] POS_MAX      = 10'd490,
  parameter logic [9:0] FWD_STEP     = 10'd2,
  parameter logic [9:0] BWD_STEP     = 10'd1,
  parameter int         START_FRAMES = 5,
  parameter int         END_FRAMES   = 3,
  parameter int         PULL_FRAMES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_fwd,
  input  logic       btn_bwd,
  input  logic       btn_attack,
  output logic [3:0] currentstate,
  output logic [9:0] posx,
  output logic       hitbox_active,
  output logic       attack_busy
);

  logic [3:0]       state_q, state_d;
  logic [9:0]       posx_q, posx_d;
  logic             arm_q, arm_d;
  logic             hitbox_q, hitbox_d;
  logic             busy_q, busy_d;

  logic             decide;
  logic             attack_start;
  logic             timer_load;
  logic             phase_done;
  logic [CNT_W-1:0] last_cnt;
  logic [10:0]      fwd_sum;
  logic [10:0]      bwd_floor;

  // 11-bit sums so a step near the top of the 10-bit range cannot wrap.
  assign fwd_sum   = {1'b0, posx_q} + {1'b0, FWD_STEP};
  assign bwd_floor = {1'b0, POS_MIN} + {1'b0, BWD_STEP};

  always_comb begin
    state_d      = state_q;
    posx_d       = posx_q;
    arm_d        = arm_q;
    decide       = 1'b0;
    attack_start = 1'b0;
    timer_load   = 1'b0;

    case (state_q)
      ST_ATK_START: last_cnt = CNT_W'(START_FRAMES - 1);
      ST_ATK_END:   last_cnt = CNT_W'(END_FRAMES - 1);
      ST_ATK_PULL:  last_cnt = CNT_W'(PULL_FRAMES - 1);
      default:      last_cnt = '0;
    endcase

    if (frame_tick) begin
      case (state_q)
        ST_IDLE, ST_FORWARD, ST_BACKWARD: decide = 1'b1;
        ST_ATK_START: if (phase_done) state_d = ST_ATK_END;
        ST_ATK_END:   if (phase_done) state_d = ST_ATK_PULL;
        // The last PULL frame hands straight over to the normal decision.
        ST_ATK_PULL:  if (phase_done) decide = 1'b1;
        default:      state_d = ST_IDLE;
      endcase

      if (decide) begin
        if (btn_attack && arm_q) begin
          state_d      = ST_ATK_START;
          attack_start = 1'b1;
        end else if (btn_fwd ^ btn_bwd) begin
          state_d = btn_fwd ? ST_FORWARD : ST_BACKWARD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Movement lands on the same edge that selects the walking state.
      if (state_d == ST_FORWARD) begin
        posx_d = (fwd_sum > {1'b0, POS_MAX}) ? POS_MAX : fwd_sum[9:0];
      end else if (state_d == ST_BACKWARD) begin
        posx_d = ({1'b0, posx_q} < bwd_floor) ? POS_MIN : (posx_q - BWD_STEP);
      end

      // A held attack button keeps the arm flag clear until released.
      if (attack_start) begin
        arm_d = 1'b0;
      end else if (!btn_attack) begin
        arm_d = 1'b1;
      end

      // Every state change enters a new phase; restart its frame count.
      timer_load = (state_d != state_q);
    end

    // Decoded from the next state so the registered flags line up with state_q.
    hitbox_d = (state_d == ST_ATK_END);
    busy_d   = is_attack(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      posx_q   <= INIT_X;
      arm_q    <= 1'b1;
      hitbox_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      posx_q   <= posx_d;
      arm_q    <= arm_d;
      hitbox_q <= hitbox_d;
      busy_q   <= busy_d;
    end
  end

  anim_phase_timer u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .tick_en  (frame_tick),
    .last_cnt (last_cnt),
    .tc       (phase_done)
  );

  assign currentstate  = state_q;
  assign posx          = posx_q;
  assign hitbox_active = hitbox_q;
  assign attack_busy   = busy_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Testbench for sprite_anim_ctrl. Directed scenarios plus a randomized run,
// all compared against a frame-level behavioural model kept in this file.
module tb_sprite_anim_ctrl;

  localparam int INIT_X = 100;
  localparam int P_MIN  = 0;
  localparam int P_MAX  = 490;
  localparam int F_STEP = 2;
  localparam int B_STEP = 1;
  localparam int N_START = 5;
  localparam int N_END   = 3;
  localparam int N_PULL  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_fwd = 1'b0;
  logic       btn_bwd = 1'b0;
  logic       btn_attack = 1'b0;
  logic [3:0] currentstate;
  logic [9:0] posx;
  logic       hitbox_active;
  logic       attack_busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: sprite state, position, arm flag, frames remaining in attack phase.
  int m_state, m_posx, m_arm, m_left;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

  sprite_anim_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .btn_fwd       (btn_fwd),
    .btn_bwd       (btn_bwd),
    .btn_attack    (btn_attack),
    .currentstate  (currentstate),
    .posx          (posx),
    .hitbox_active (hitbox_active),
    .attack_busy   (attack_busy)
  );

  task automatic model_reset();
    m_state = 0; m_posx = INIT_X; m_arm = 1; m_left = 0;
  endtask

  task automatic model_step(input bit f, input bit b, input bit a);
    bit decide;
    bit start;
    decide = 0; start = 0;
    if (m_state >= 3 && m_state <= 5) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_state == 3)      begin m_state = 4; m_left = N_END;  end
        else if (m_state == 4) begin m_state = 5; m_left = N_PULL; end
        else decide = 1;
      end
    end else begin
      decide = 1;
    end
    if (decide) begin
      if (a && m_arm == 1) begin
        m_state = 3; m_left = N_START; start = 1;
      end else if (f != b) begin
        if (f) begin
          m_state = 1;
          m_posx = (m_posx + F_STEP > P_MAX) ? P_MAX : m_posx + F_STEP;
        end else begin
          m_state = 2;
          m_posx = (m_posx < P_MIN + B_STEP) ? P_MIN : m_posx - B_STEP;
        end
      end else begin
        m_state = 0;
      end
    end
    if (start) m_arm = 0;
    else if (!a) m_arm = 1;
  endtask

  // One frame: inputs set at a falling edge, frame_tick high across one
  // rising edge, outputs then sampled at the following falling edge.
  task automatic do_tick(input bit f, input bit b, input bit a);
    @(negedge clk);
    btn_fwd = f; btn_bwd = b; btn_attack = a; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_step(f, b, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'($urandom_range(0, 1));
    btn_fwd = 1'($urandom_range(0, 1));
    btn_bwd = 1'($urandom_range(0, 1));
    btn_attack = 1'($urandom_range(0, 1));
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0;
    btn_fwd = 1'b0; btn_bwd = 1'b0; btn_attack = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (currentstate !== 4'd0) $display("FAIL reset_state: got %0d want 0", currentstate); else pass_cnt++;
    total_cnt++;
    if (posx !== 10'(INIT_X)) $display("FAIL reset_posx: got %0d want %0d", posx, INIT_X); else pass_cnt++;
    total_cnt++;
    if (hitbox_active !== 1'b0) $display("FAIL reset_hitbox: got %b want 0", hitbox_active); else pass_cnt++;
    total_cnt++;
    if (attack_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", attack_busy); else pass_cnt++;
    $display("test_reset: state=%0d posx=%0d", currentstate, posx);
  endtask

  task automatic test_forward();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_tick(1, 0, 0);
      total_cnt++;
      if (currentstate !== 4'd1) $display("FAIL fwd_state tick %0d: got %0d want 1", i, currentstate); else pass_cnt++;
    end
    total_cnt++;
    if (posx !== 10'd120) $display("FAIL fwd_posx: got %0d want 120", posx); else pass_cnt++;
    $display("test_forward: posx=%0d", posx);
  endtask

  task automatic test_clamp();
    do_reset();
    while (m_posx < P_MAX) do_tick(1, 0, 0);
    do_tick(0, 1, 0);
    total_cnt++;
    if (posx !== 10'd489) $display("FAIL clamp_setup: got %0d want 489", posx); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      do_tick(1, 0, 0);
      total_cnt++;
      if (posx !== 10'd490) $display("FAIL clamp_max tick %0d: got %0d want 490", i, posx); else pass_cnt++;
    end
    while (m_posx > P_MIN) do_tick(0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      do_tick(0, 1, 0);
      total_cnt++;
      if (posx !== 10'd0) $display("FAIL clamp_min tick %0d: got %0d want 0", i, posx); else pass_cnt++;
      total_cnt++;
      if (currentstate !== 4'd2) $display("FAIL clamp_min_state: got %0d want 2", currentstate); else pass_cnt++;
    end
    $display("test_clamp: posx=%0d", posx);
  endtask

  task automatic test_attack();
    int exp_s;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      do_tick(0, 0, 1);
      exp_s = (i <= N_START) ? 3 : (i <= N_START + N_END) ? 4 :
              (i <= N_START + N_END + N_PULL) ? 5 : 0;
      total_cnt++;
      if (currentstate !== 4'(exp_s)) $display("FAIL atk_state tick %0d: got %0d want %0d", i, currentstate, exp_s); else pass_cnt++;
      total_cnt++;
      if (hitbox_active !== (exp_s == 4)) $display("FAIL atk_hitbox tick %0d: got %b want %b", i, hitbox_active, exp_s == 4); else pass_cnt++;
      total_cnt++;
      if (attack_busy !== (exp_s >= 3)) $display("FAIL atk_busy tick %0d: got %b want %b", i, attack_busy, exp_s >= 3); else pass_cnt++;
    end
    do_tick(0, 0, 0);
    total_cnt++;
    if (currentstate !== 4'd0) $display("FAIL atk_release: got %0d want 0", currentstate); else pass_cnt++;
    do_tick(0, 0, 1);
    total_cnt++;
    if (currentstate !== 4'd3) $display("FAIL atk_rearm: got %0d want 3", currentstate); else pass_cnt++;
    $display("test_attack: final state=%0d", currentstate);
  endtask

  task automatic test_combo();
    do_reset();
    for (int i = 0; i < 3; i++) do_tick(1, 0, 0);
    do_tick(1, 1, 0);
    total_cnt++;
    if (currentstate !== 4'd0) $display("FAIL both_dirs_state: got %0d want 0", currentstate); else pass_cnt++;
    total_cnt++;
    if (posx !== 10'd106) $display("FAIL both_dirs_posx: got %0d want 106", posx); else pass_cnt++;
    do_tick(1, 0, 1);
    total_cnt++;
    if (currentstate !== 4'd3) $display("FAIL fwd_atk_state: got %0d want 3", currentstate); else pass_cnt++;
    total_cnt++;
    if (posx !== 10'd106) $display("FAIL fwd_atk_posx: got %0d want 106", posx); else pass_cnt++;
    $display("test_combo: state=%0d posx=%0d", currentstate, posx);
  endtask

  task automatic test_rst_mid_attack();
    do_reset();
    for (int i = 0; i < 5; i++) do_tick(1, 0, 0);
    for (int i = 0; i < N_START + 1; i++) do_tick(0, 0, 1);
    total_cnt++;
    if (hitbox_active !== 1'b1) $display("FAIL mid_atk_hitbox: got %b want 1", hitbox_active); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1; frame_tick = 1'b1; btn_attack = 1'b1;
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0; btn_attack = 1'b0;
    model_reset();
    total_cnt++;
    if (currentstate !== 4'd0) $display("FAIL rst_abort_state: got %0d want 0", currentstate); else pass_cnt++;
    total_cnt++;
    if (posx !== 10'd100) $display("FAIL rst_abort_posx: got %0d want 100", posx); else pass_cnt++;
    total_cnt++;
    if (hitbox_active !== 1'b0) $display("FAIL rst_abort_hitbox: got %b want 0", hitbox_active); else pass_cnt++;
    $display("test_rst_mid_attack: state=%0d posx=%0d", currentstate, posx);
  endtask

  task automatic test_hold();
    do_reset();
    do_tick(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      btn_fwd = 1'($urandom_range(0, 1));
      btn_bwd = 1'($urandom_range(0, 1));
      btn_attack = 1'($urandom_range(0, 1));
      @(negedge clk);
      total_cnt++;
      if (currentstate !== 4'(m_state)) $display("FAIL hold_state cyc %0d: got %0d want %0d", i, currentstate, m_state); else pass_cnt++;
      total_cnt++;
      if (posx !== 10'(m_posx)) $display("FAIL hold_posx cyc %0d: got %0d want %0d", i, posx, m_posx); else pass_cnt++;
    end
    $display("test_hold: state=%0d posx=%0d", currentstate, posx);
  endtask

  task automatic test_random();
    bit f, b, a;
    int gaps;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          @(negedge clk);
          btn_fwd = 1'($urandom_range(0, 1));
          btn_bwd = 1'($urandom_range(0, 1));
          btn_attack = 1'($urandom_range(0, 1));
        end
        f = 1'($urandom_range(0, 1));
        b = ($urandom_range(0, 3) == 0);
        a = ($urandom_range(0, 3) == 0);
        do_tick(f, b, a);
      end
      total_cnt++;
      if (currentstate !== 4'(m_state)) $display("FAIL rnd_state step %0d: got %0d want %0d", n, currentstate, m_state); else pass_cnt++;
      total_cnt++;
      if (posx !== 10'(m_posx)) $display("FAIL rnd_posx step %0d: got %0d want %0d", n, posx, m_posx); else pass_cnt++;
      total_cnt++;
      if (hitbox_active !== (m_state == 4)) $display("FAIL rnd_hitbox step %0d: got %b want %b", n, hitbox_active, m_state == 4); else pass_cnt++;
      total_cnt++;
      if (attack_busy !== (m_state >= 3)) $display("FAIL rnd_busy step %0d: got %b want %b", n, attack_busy, m_state >= 3); else pass_cnt++;
    end
    $display("test_random: final state=%0d posx=%0d", currentstate, posx);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_clamp();
    test_attack();
    test_combo();
    test_rst_mid_attack();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
